// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter (shift-add-3) with valid/ready handshake,
// overflow saturation to all nines and leading-zero blanking flags.
module bcd_digit_converter #(
    parameter int unsigned W = 6,
    parameter int unsigned D = 2
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   bin_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [4*D-1:0] bcd_o,
    output logic           overflow_o,
    output logic [D-1:0]   blank_o
);

    // Largest representable value 10^D-1; D>=10 already exceeds any 32-bit input.
    function automatic logic [63:0] calc_max_val(input int unsigned digits);
        logic [63:0] v;
        v = 64'd1;
        for (int unsigned i = 0; i < ((digits > 10) ? 10 : digits); i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam int unsigned DI     = (W + 2) / 3;
    localparam int unsigned RW     = 4 * DI + W;
    localparam int unsigned EW     = 4 * (DI + D);
    localparam int unsigned CW     = (W > 1) ? $clog2(W) : 1;
    localparam logic [63:0] MaxVal = calc_max_val(D);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   shr_q, shr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [4*D-1:0]  bcd_q, bcd_d;
    logic            overflow_q, overflow_d;
    logic [D-1:0]    blank_q, blank_d;

    logic [RW-1:0]   shifted;
    logic [EW-1:0]   digits_ext;
    logic [4*D-1:0]  res_bcd;
    logic [D-1:0]    res_blank;

    // One double-dabble step: correct every BCD digit >= 5, then shift left by one.
    always_comb begin
        logic [RW-1:0] adj;
        adj = shr_q;
        for (int unsigned i = 0; i < DI; i++) begin
            if (adj[W+4*i +: 4] >= 4'd5) begin
                adj[W+4*i +: 4] = adj[W+4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[RW-2:0], 1'b0};
    end

    // Result formed from the final shift: saturation and leading-zero flags.
    always_comb begin
        logic nz;
        digits_ext = EW'(shifted[RW-1:W]);
        res_bcd    = digits_ext[4*D-1:0];
        res_blank  = '0;
        nz         = 1'b0;
        for (int k = int'(D) - 1; k >= 1; k--) begin
            nz           = nz | (res_bcd[4*k +: 4] != 4'd0);
            res_blank[k] = ~nz;
        end
        if (ovf_q) begin
            res_bcd   = {D{4'h9}};
            res_blank = '0;
        end
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        state_d    = state_q;
        shr_d      = shr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        blank_d    = blank_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    shr_d   = RW'(bin_i);
                    cnt_d   = '0;
                    ovf_d   = 64'(bin_i) > MaxVal;
                    state_d = StShift;
                end
            end
            StShift: begin
                shr_d = shifted;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    bcd_d      = res_bcd;
                    overflow_d = ovf_q;
                    blank_d    = res_blank;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards any conversion in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            shr_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            blank_q    <= '0;
        end else begin
            state_q    <= state_d;
            shr_q      <= shr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            blank_q    <= blank_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign bcd_o       = bcd_q;
    assign overflow_o  = overflow_q;
    assign blank_o     = blank_q;

endmodule
